// File: rtl/alu_word_sequencer.sv
// Multi-byte ALU sequencer: runs a BYTES-wide operation through one 8-bit ALU, LSB first, with carry chaining.
// Optional zero flag on the response when ALU_SEQ_ZERO_FLAG_EN is defined.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready=1
// RUN   | driving the ALU one byte per cycle
// DONE  | response valid, held until rsp_ready
module alu_word_sequencer #(
  parameter int BYTES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [2:0]         cmd_oper,
  input  logic [8*BYTES-1:0] cmd_a,
  input  logic [8*BYTES-1:0] cmd_b,
  input  logic               cmd_c_in,
  output logic [2:0]         alu_oper,
  output logic [7:0]         alu_a,
  output logic [7:0]         alu_b,
  output logic               alu_c_in,
  input  logic [7:0]         alu_sum,
  input  logic               alu_c_out,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [8*BYTES-1:0] rsp_result,
`ifdef ALU_SEQ_ZERO_FLAG_EN
  output logic               rsp_zero,
`endif
  output logic               rsp_c_out
);

  localparam int KW = (BYTES > 1) ? $clog2(BYTES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_nxt;
  logic [2:0]         oper_q;
  logic [8*BYTES-1:0] a_q, b_q, result_q;
  logic               cin_q, carry_q;
  logic [KW-1:0]      k;
  logic               accept, last_byte, arith;
  logic [7:0]         byte_a, byte_b;

  assign accept    = (state == IDLE) && cmd_valid;
  assign last_byte = (k == KW'(BYTES - 1));
  assign arith     = (oper_q < 3'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_valid) state_nxt = RUN;
      RUN:     if (last_byte) state_nxt = DONE;
      DONE:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    byte_a = 8'd0;
    byte_b = 8'd0;
    for (int i = 0; i < BYTES; i++) begin
      if (k == KW'(i)) begin
        byte_a = a_q[8*i +: 8];
        byte_b = b_q[8*i +: 8];
      end
    end
  end

  always_comb begin
    cmd_ready = (state == IDLE);
    rsp_valid = (state == DONE);
    alu_oper  = 3'd0;
    alu_a     = 8'd0;
    alu_b     = 8'd0;
    alu_c_in  = 1'b0;
    if (state == RUN) begin
      alu_oper = oper_q;
      alu_a    = byte_a;
      alu_b    = byte_b;
      // opcode 010 has its carry inverted inside the ALU, so re-invert the chained carry
      if (arith) begin
        if (k == '0)               alu_c_in = cin_q;
        else if (oper_q == 3'b010) alu_c_in = ~carry_q;
        else                       alu_c_in = carry_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oper_q   <= 3'd0;
      a_q      <= '0;
      b_q      <= '0;
      cin_q    <= 1'b0;
      carry_q  <= 1'b0;
      k        <= '0;
      result_q <= '0;
    end else if (accept) begin
      oper_q  <= cmd_oper;
      a_q     <= cmd_a;
      b_q     <= cmd_b;
      cin_q   <= cmd_c_in;
      carry_q <= 1'b0;
      k       <= '0;
    end else if (state == RUN) begin
      carry_q <= arith ? alu_c_out : 1'b0;
      k       <= k + KW'(1);
      for (int i = 0; i < BYTES; i++)
        if (k == KW'(i)) result_q[8*i +: 8] <= alu_sum;
    end
  end

  assign rsp_result = result_q;
  assign rsp_c_out  = carry_q;

`ifdef ALU_SEQ_ZERO_FLAG_EN
  logic zero_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               zero_q <= 1'b0;
    else if (accept)          zero_q <= 1'b0;
    else if (state == RUN)    zero_q <= (alu_sum == 8'd0) && ((k == '0) || zero_q);
  end

  assign rsp_zero = zero_q;
`endif

endmodule

// File: tb/tb_alu_word_sequencer.sv
// Directed bench for alu_word_sequencer (BYTES=4) with a behavioural 8-bit ALU attached.
module tb_alu_word_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_c_in;
  logic [2:0]  cmd_oper;
  logic [31:0] cmd_a, cmd_b;
  logic [2:0]  alu_oper;
  logic [7:0]  alu_a, alu_b, alu_sum;
  logic        alu_c_in, alu_c_out;
  logic        rsp_valid, rsp_ready, rsp_c_out;
  logic [31:0] rsp_result;
`ifdef ALU_SEQ_ZERO_FLAG_EN
  logic        rsp_zero;
`endif

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  alu_word_sequencer #(.BYTES(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_oper   (cmd_oper),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_c_in   (cmd_c_in),
    .alu_oper   (alu_oper),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_c_in   (alu_c_in),
    .alu_sum    (alu_sum),
    .alu_c_out  (alu_c_out),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
`ifdef ALU_SEQ_ZERO_FLAG_EN
    .rsp_zero   (rsp_zero),
`endif
    .rsp_c_out  (rsp_c_out)
  );

  // Behavioural ALU; logic ops return a junk carry of 1 so the sequencer must mask it.
  logic [8:0] alu_tmp;
  always_comb begin
    alu_tmp = 9'd0;
    case (alu_oper)
      3'b000:  alu_tmp = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_c_in};
      3'b001:  alu_tmp = {1'b0, alu_a} + {1'b0, ~alu_b} + {8'd0, alu_c_in};
      3'b010:  alu_tmp = {1'b0, ~alu_a} + {1'b0, alu_b} + {8'd0, ~alu_c_in};
      3'b011:  alu_tmp = {1'b1, alu_a | alu_b};
      3'b100:  alu_tmp = {1'b1, alu_a & alu_b};
      3'b101:  alu_tmp = {1'b1, ~alu_a & alu_b};
      3'b110:  alu_tmp = {1'b1, alu_a ^ alu_b};
      default: alu_tmp = {1'b1, ~(alu_a ^ alu_b)};
    endcase
  end
  assign alu_sum   = alu_tmp[7:0];
  assign alu_c_out = alu_tmp[8];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  // exp_cin bit i is the alu_c_in expected while byte i is on the ALU
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic cin, input logic [31:0] exp_r, input logic exp_c,
                       input logic [3:0] exp_cin, input logic exp_z, input logic release_rdy);
    @(negedge clk);
    cmd_oper  = op;
    cmd_a     = a;
    cmd_b     = b;
    cmd_c_in  = cin;
    cmd_valid = 1'b1;
    rsp_ready = release_rdy;
    check("cmd_ready_idle", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_a     = ~a;
    cmd_b     = ~b;
    cmd_oper  = ~op;
    cmd_c_in  = ~cin;
    for (int i = 0; i < 4; i++) begin
      check("alu_c_in", alu_c_in, exp_cin[i]);
      check("alu_a", alu_a, a[8*i +: 8]);
      check("alu_b", alu_b, b[8*i +: 8]);
      check("alu_oper", alu_oper, op);
      check("rsp_valid_run", rsp_valid, 0);
      check("cmd_ready_run", cmd_ready, 0);
      @(posedge clk); #1;
    end
    check("rsp_valid_done", rsp_valid, 1);
    check("rsp_result", rsp_result, exp_r);
    check("rsp_c_out", rsp_c_out, exp_c);
`ifdef ALU_SEQ_ZERO_FLAG_EN
    check("rsp_zero", rsp_zero, exp_z);
`else
    if (exp_z) begin end
`endif
    check("alu_idle_done", {alu_oper, alu_a, alu_b, alu_c_in}, 0);
    if (release_rdy) begin
      @(posedge clk); #1;
      check("rsp_valid_released", rsp_valid, 0);
      check("cmd_ready_after", cmd_ready, 1);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_oper  = 3'd0;
    cmd_a     = 32'd0;
    cmd_b     = 32'd0;
    cmd_c_in  = 1'b0;
    rsp_ready = 1'b0;
    #12;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_result", rsp_result, 0);
    check("rst_rsp_c_out", rsp_c_out, 0);
    check("rst_alu", {alu_oper, alu_a, alu_b, alu_c_in}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(3'b000, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 4'b1110, 1'b1, 1'b1);
    do_op(3'b001, 32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 1'b0, 4'b0001, 1'b0, 1'b1);
    do_op(3'b001, 32'h1234_5678, 32'h1234_5678, 1'b1, 32'h0000_0000, 1'b1, 4'b1111, 1'b1, 1'b1);
    do_op(3'b010, 32'h0000_0001, 32'h0000_0000, 1'b0, 32'hFFFF_FFFF, 1'b0, 4'b1110, 1'b0, 1'b1);
    do_op(3'b110, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1, 32'h0FF0_0FF0, 1'b0, 4'b0000, 1'b0, 1'b1);

    // response back-pressure: result frozen and new commands refused
    do_op(3'b000, 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 4'b0010, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_oper  = 3'b011;
      cmd_a     = 32'hAAAA_0000 + i;
      cmd_b     = 32'h5555_5555;
      check("hold_rsp_valid", rsp_valid, 1);
      check("hold_rsp_result", rsp_result, 32'h0000_0100);
      check("hold_rsp_c_out", rsp_c_out, 0);
      check("hold_cmd_ready", cmd_ready, 0);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("hold_release_idle", cmd_ready, 1);
    check("hold_release_valid", rsp_valid, 0);
    @(posedge clk); #1;
    check("idle_no_cmd", cmd_ready, 1);

    // reset in the middle of RUN, after byte 1 has been captured
    @(negedge clk);
    cmd_oper  = 3'b000;
    cmd_a     = 32'h1111_1111;
    cmd_b     = 32'h2222_2222;
    cmd_c_in  = 1'b0;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_run_alu_a", alu_a, 8'h11);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_cmd_ready", cmd_ready, 1);
    check("abort_rsp_valid", rsp_valid, 0);
    check("abort_rsp_result", rsp_result, 0);
    check("abort_rsp_c_out", rsp_c_out, 0);
    check("abort_alu", {alu_oper, alu_a, alu_b, alu_c_in}, 0);
`ifdef ALU_SEQ_ZERO_FLAG_EN
    check("abort_rsp_zero", rsp_zero, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check("abort_no_rsp", rsp_valid, 0);
    end

    do_op(3'b111, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 1'b0, 4'b0000, 1'b0, 1'b1);
    do_op(3'b101, 32'h0F0F_00FF, 32'hFFFF_FF00, 1'b1, 32'hF0F0_FF00, 1'b0, 4'b0000, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/alu_word_sequencer.md
# alu_word_sequencer

Multi-cycle controller that executes BYTES×8-bit operations by driving the team's combinational 8-bit ALU one byte per cycle, LSB first, chaining carry between bytes. It accepts commands on a valid/ready request channel, drives the ALU's oper/a/b/c_in inputs, captures sum/c_out, and returns the assembled word on a valid/ready response channel. It sits between the datapath issue logic and a single 8-bit ALU instance.

## Interface
- BYTES, 4: operand width in bytes; legal range 1..8.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  request valid.
- cmd_ready  out  1  high only in IDLE.
- cmd_oper  in  3  ALU opcode (000 add, 001 a+~b+c, 010 ~a+b+~c, 011 or, 100 and, 101 ~a&b, 110 xor, 111 xnor).
- cmd_a, cmd_b  in  8*BYTES  operands.
- cmd_c_in  in  1  carry into byte 0.
- alu_oper  out  3  to ALU oper.
- alu_a, alu_b  out  8  current operand byte.
- alu_c_in  out  1  to ALU c_in.
- alu_sum  in  8  from ALU sum.
- alu_c_out  in  1  from ALU c_out.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  result accepted.
- rsp_result  out  8*BYTES  assembled result.
- rsp_c_out  out  1  carry out of top byte (0 for logic ops).
- rsp_zero  out  1  present only with ALU_SEQ_ZERO_FLAG_EN.

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- IDLE: cmd_ready=1. cmd_valid&cmd_ready at an edge: capture oper, a, b, c_in; byte index k←0; → RUN.
- RUN: alu_oper=captured oper; alu_a/alu_b = byte k of captured a/b (combinational from registers). Each edge: result byte k←alu_sum, carry register←alu_c_out, k←k+1; after byte BYTES-1 → DONE.
- alu_c_in per byte: k=0 → captured c_in for opcodes 000/001/010. k>0: 000/001 → previous alu_c_out; 010 → ~previous alu_c_out (ALU inverts c_in for this opcode). Opcodes 011–111 → alu_c_in=0 for all bytes.
- rsp_c_out = alu_c_out of byte BYTES-1 for 000/001/010; forced 0 for logic opcodes.
- DONE: rsp_valid=1; rsp_result/rsp_c_out held stable until rsp_valid&rsp_ready at an edge → IDLE. No command accepted in RUN or DONE (no overlap).
- Outside RUN: alu_oper, alu_a, alu_b, alu_c_in all 0.
- cmd_* inputs ignored outside the acceptance edge; changing them during RUN has no effect.

## Timing
- Reset (async assert, any state): state=IDLE, cmd_ready=1, rsp_valid=0, rsp_result=0, rsp_c_out=0, rsp_zero=0, alu_* =0. An in-flight operation is aborted with no response.
- Latency: acceptance edge E0; bytes captured at E1..E_BYTES; rsp_valid high after E_BYTES (BYTES cycles after acceptance).
- rsp_ready high when rsp_valid rises: IDLE after next edge, cmd_ready high one cycle later; throughput one op per BYTES+2 cycles max.
- rsp_ready held low: DONE persists indefinitely, outputs frozen.
- BYTES=1: single RUN cycle, same rules.

## Configuration
- ALU_SEQ_ZERO_FLAG_EN defined: rsp_zero port exists; rsp_zero=1 iff all BYTES result bytes are 0, accumulated during RUN (AND of per-byte zero), valid with rsp_valid, cleared by reset and on acceptance.
- Undefined: rsp_zero port and its logic absent; all other behaviour identical.

## Test plan
- BYTES=4, oper 000, a=0xFFFFFFFF, b=0x00000001, c_in=0 → rsp_result=0x00000000, rsp_c_out=1, rsp_zero=1; rsp_valid 4 cycles after accept.
- oper 001, a=0x00000000, b=0x00000001, c_in=1 → rsp_result=0xFFFFFFFF, rsp_c_out=0; a=0x12345678, b=0x12345678, c_in=1 → 0x00000000, c_out=1.
- oper 010, a=0x00000001, b=0, c_in=0 → 0xFFFFFFFF, c_out=0; check alu_c_in=0,1,1,1 on bytes 0..3.
- oper 110, a=0xF0F0F0F0, b=0xFF00FF00, c_in=1 → 0x0FF00FF0, rsp_c_out=0, alu_c_in=0 every byte.
- Hold rsp_ready=0 for 10 cycles → rsp_valid and rsp_result stable, cmd_ready=0, new cmd_valid ignored; then rsp_ready=1 → IDLE next edge.
- Assert rst_n=0 mid-RUN (after byte 1) → all outputs 0 immediately, cmd_ready=1; no response ever issued for the aborted command.
